mul_pipe: RTL and testbench



---
 rtl/mul_pkg.sv | 25 ++
 rtl/mul_stage.sv | 21 ++
 rtl/mul_pipe.sv | 96 +++++++++
 tb/tb_mul_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared widths, op encodings and the per-stage payload of the pipelined multiplier.
package mul_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned PW             = 2 * XLEN;
  localparam int unsigned BITS_PER_STAGE = 4;
  localparam int unsigned NUM_STAGES     = XLEN / BITS_PER_STAGE;
  localparam int unsigned TAG_W          = 5;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef struct packed {
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [XLEN-1:0]  mplier;
    logic             neg;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } stage_t;

endpackage

// File: rtl/mul_stage.sv
// Combinational shift-add slice consuming BITS_PER_STAGE multiplier bits, LSB first.
module mul_stage
  import mul_pkg::*;
(
  input  stage_t d,
  output stage_t q_c
);

  // Accumulate the shifted multiplicand for each set multiplier bit, then retire those bits.
  always_comb begin
    q_c = d;
    for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
      if (d.mplier[i]) begin
        q_c.acc = q_c.acc + q_c.mcand;
      end
      q_c.mcand = q_c.mcand << 1;
    end
    q_c.mplier = d.mplier >> BITS_PER_STAGE;
  end

endmodule

// File: rtl/mul_pipe.sv
// Eight-stage pipelined 32x32 RV32M multiplier with tag, valid and global stall.
module mul_pipe
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             stall,
  output logic             in_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  stage_t          cond;
  stage_t          s_in  [NUM_STAGES];
  stage_t          s_out [NUM_STAGES];
  stage_t          pipe  [NUM_STAGES-1];
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] fin_result;
  logic            busy_next;

  assign in_ready = ~stall;

  // Sign/magnitude conditioning of the operands; 0x80000000 maps to magnitude 2^31.
  always_comb begin
    sign_a      = in_a[XLEN-1] & ((in_op == OP_MULH) | (in_op == OP_MULHSU));
    sign_b      = in_b[XLEN-1] & (in_op == OP_MULH);
    mag_a       = sign_a ? ((~in_a) + XLEN'(1)) : in_a;
    mag_b       = sign_b ? ((~in_b) + XLEN'(1)) : in_b;
    cond        = '0;
    cond.mcand  = PW'(mag_a);
    cond.mplier = mag_b;
    cond.neg    = sign_a ^ sign_b;
    cond.op     = in_op;
    cond.tag    = in_tag;
    cond.valid  = in_valid;
  end

  // Slice 0 is fed by the conditioned inputs, every later slice by the previous stage register.
  always_comb begin
    s_in[0] = cond;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      s_in[k] = pipe[k-1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    mul_stage u_stage (
      .d   (s_in[k]),
      .q_c (s_out[k])
    );
  end

  // Sign restore and word select, folded into the last stage ahead of the output register.
  always_comb begin
    prod       = s_out[NUM_STAGES-1].neg ? ((~s_out[NUM_STAGES-1].acc) + PW'(1))
                                         : s_out[NUM_STAGES-1].acc;
    fin_result = (s_out[NUM_STAGES-1].op == OP_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    busy_next  = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      busy_next = busy_next | s_out[k].valid;
    end
  end

  // Stage and output registers: reset clears valids, stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_STAGES - 1; k++) begin
        pipe[k].valid <= 1'b0;
      end
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      busy       <= 1'b0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < NUM_STAGES - 1; k++) begin
        pipe[k] <= s_out[k];
      end
      out_valid  <= s_out[NUM_STAGES-1].valid;
      out_result <= fin_result;
      out_tag    <= s_out[NUM_STAGES-1].tag;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: directed vectors, latency, stall and reset flush.
module tb_mul_pipe;
  import mul_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             stall;
  logic             in_ready;
  logic             out_valid;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    int               due;
  } exp_t;

  exp_t sb[$];

  mul_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .stall      (stall),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] p;
    sa  = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    sbv = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = sa * sbv;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: a result is consumed on the last cycle it is presented with stall low.
  always @(negedge clk) begin
    if (!rst && out_valid && !stall) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0d result 0x%08h, expected none", out_tag, out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_tag", 32'(out_tag), 32'(e.tag));
        check("out_result", out_result, e.res);
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] res, input int lat);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    sb.push_back('{tag: tag, res: res, due: cyc + lat});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    logic        f_valid;
    logic        f_busy;
    logic [31:0] f_result;
    logic [TAG_W-1:0] f_tag;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = OP_MUL;
    in_a     = '0;
    in_b     = '0;
    in_tag   = '0;
    stall    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Basic MUL with exact +8 latency.
    issue(OP_MUL, 32'd7, 32'd6, 5'd3, 32'h0000002A, 8);
    idle(1);
    @(negedge clk);
    check("busy_inflight", 32'(busy), 32'd1);
    drain();

    // All-ones back to back: low word then unsigned high word.
    issue(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, 8);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 8);
    idle(1);
    drain();

    // Signed corner cases.
    issue(OP_MULH,   32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 8);
    issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000, 8);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, 8);
    issue(OP_MULH,   32'hFFFFFFFF, 32'h00000000, 5'd7, 32'h00000000, 8);
    issue(OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 8);
    idle(1);
    drain();

    // Eight consecutive ops, tags 0..7, checked against the 64-bit model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 2'($urandom_range(0, 3));
      issue(ro, ra, rb, TAG_W'(i), ref_mul(ro, ra, rb), 8);
    end
    idle(1);
    drain();

    // Four ops then a three-cycle stall with a would-be op (tag 9) on the inputs.
    issue(OP_MUL,   32'd3,        32'd5,        5'd10, 32'h0000000F, 11);
    issue(OP_MUL,   32'd100,      32'd100,      5'd11, 32'h00002710, 11);
    issue(OP_MULHU, 32'h00010000, 32'h00010000, 5'd12, 32'h00000001, 11);
    issue(OP_MULH,  32'hFFFFFFFE, 32'd3,        5'd13, 32'hFFFFFFFF, 11);
    f_valid  = 1'b0;
    f_busy   = 1'b0;
    f_result = '0;
    f_tag    = '0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      stall    = 1'b1;
      in_valid = 1'b1;
      in_op    = OP_MUL;
      in_a     = 32'd2;
      in_b     = 32'd2;
      in_tag   = 5'd9;
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (s == 0) begin
        f_valid  = out_valid;
        f_busy   = busy;
        f_result = out_result;
        f_tag    = out_tag;
        check("stall_busy", 32'(busy), 32'd1);
      end else begin
        check("stall_hold_valid", 32'(out_valid), 32'(f_valid));
        check("stall_hold_busy", 32'(busy), 32'(f_busy));
        check("stall_hold_result", out_result, f_result);
        check("stall_hold_tag", 32'(out_tag), 32'(f_tag));
      end
    end
    @(posedge clk);
    #1;
    stall    = 1'b0;
    in_valid = 1'b0;
    drain();

    // Fill with five ops, then reset flushes them all.
    for (int i = 0; i < 5; i++) begin
      issue(OP_MUL, 32'(i + 1), 32'd9, TAG_W'(20 + i), 32'(9 * (i + 1)), 8);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
    end
    issue(OP_MUL, 32'd12, 32'd12, 5'd25, 32'h00000090, 8);
    idle(1);
    drain();

    @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
